// File: rtl/switch_ingress_arbiter.sv
// switch_ingress_arbiter
// Ingress stage feeding the single addr/data/vld input of the two-port switch.
// Each of the two sources pushes beats through a valid/ready handshake into its
// own FIFO. A round-robin arbiter pops at most one beat per clock into a
// registered output. vld is a one-cycle pulse per beat, because the switch
// input has no back-pressure.
//
// Ports:
//   clk                    clock, rising edge
//   rst                    asynchronous active-high reset
//   s0_vld/s0_rdy          source 0 handshake; s0_rdy = FIFO 0 not full
//   s0_addr/s0_data        source 0 beat
//   s1_vld/s1_rdy          source 1 handshake; s1_rdy = FIFO 1 not full
//   s1_addr/s1_data        source 1 beat
//   pause                  when high, nothing is popped
//   addr/data/vld          registered beat to the switch
//   s0_cnt/s1_cnt/full_cnt (only with SWITCH_INGRESS_STATS_EN) saturating
//                          counters: beats granted per source, stalled
//                          handshake cycles summed over both sources
//
// Optional feature macro: SWITCH_INGRESS_STATS_EN
module switch_ingress_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_vld,
  output logic                  s0_rdy,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s1_vld,
  output logic                  s1_rdy,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  pause,
`ifdef SWITCH_INGRESS_STATS_EN
  output logic [15:0]           s0_cnt,
  output logic [15:0]           s1_cnt,
  output logic [15:0]           full_cnt,
`endif
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  vld
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = ADDR_WIDTH + DATA_WIDTH;

  logic [1:0]    w_in_vld;
  logic [WW-1:0] w_in_word [2];
  logic [1:0]    w_rdy;
  logic [1:0]    w_nempty;
  logic [1:0]    w_pop;
  logic [WW-1:0] w_head    [2];

  logic          w_grant_any;
  logic          w_grant_sel;

  logic                  r_last_grant;
  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  assign w_in_vld     = {s1_vld, s0_vld};
  assign w_in_word[0] = {s0_addr, s0_data};
  assign w_in_word[1] = {s1_addr, s1_data};

  // Per-source FIFO. The count is kept separately from the pointers so that
  // full and empty are unambiguous when the pointers are equal.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WW-1:0] r_mem [DEPTH];
      logic [PW-1:0] r_wptr;
      logic [PW-1:0] r_rptr;
      logic [CW-1:0] r_cnt;
      logic          w_push;

      // Ready depends only on the count: a full FIFO refuses a push even
      // when it is being popped on the same edge.
      assign w_rdy[gi]    = (r_cnt != CW'(DEPTH));
      assign w_nempty[gi] = (r_cnt != '0);
      assign w_push       = w_in_vld[gi] && w_rdy[gi];
      assign w_head[gi]   = r_mem[r_rptr];

      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wptr] <= w_in_word[gi];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
          end
          if (w_pop[gi]) begin
            r_rptr <= r_rptr + 1'b1;
          end
          if (w_push && !w_pop[gi]) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (!w_push && w_pop[gi]) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end
    end
  endgenerate

  // Round robin: when both FIFOs hold data, the source that did not win
  // last time is granted; otherwise whichever one is non-empty.
  assign w_grant_any = !pause && (w_nempty != 2'b00);
  assign w_grant_sel = (&w_nempty) ? ~r_last_grant : w_nempty[1];
  assign w_pop[0]    = w_grant_any && !w_grant_sel;
  assign w_pop[1]    = w_grant_any && w_grant_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_vld <= w_grant_any;
      if (w_grant_any) begin
        {r_addr, r_data} <= w_head[w_grant_sel];
        r_last_grant     <= w_grant_sel;
      end
    end
  end

  assign s0_rdy = w_rdy[0];
  assign s1_rdy = w_rdy[1];
  assign addr   = r_addr;
  assign data   = r_data;
  assign vld    = r_vld;

`ifdef SWITCH_INGRESS_STATS_EN
  logic [15:0] r_s0_cnt;
  logic [15:0] r_s1_cnt;
  logic [15:0] r_full_cnt;
  logic [1:0]  w_stall;
  logic [16:0] w_full_sum;

  assign w_stall    = w_in_vld & ~w_rdy;
  // Both sources can stall on the same edge, so this counter may step by 2.
  assign w_full_sum = {1'b0, r_full_cnt} + 17'(w_stall[0]) + 17'(w_stall[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_cnt   <= '0;
      r_s1_cnt   <= '0;
      r_full_cnt <= '0;
    end else begin
      if (w_pop[0] && (r_s0_cnt != 16'hFFFF)) begin
        r_s0_cnt <= r_s0_cnt + 1'b1;
      end
      if (w_pop[1] && (r_s1_cnt != 16'hFFFF)) begin
        r_s1_cnt <= r_s1_cnt + 1'b1;
      end
      r_full_cnt <= w_full_sum[16] ? 16'hFFFF : w_full_sum[15:0];
    end
  end

  assign s0_cnt   = r_s0_cnt;
  assign s1_cnt   = r_s1_cnt;
  assign full_cnt = r_full_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_switch_ingress_arbiter.sv
// Testbench for switch_ingress_arbiter. A cycle table covers contention,
// alternation and FIFO-full behaviour; hand-written sequences cover single
// beat latency, pause, asynchronous reset and the optional counters. A
// per-source scoreboard (source tagged by addr[6]) checks every output beat
// against the beats the bench saw accepted, in acceptance order.
module tb_switch_ingress_arbiter;

  logic        clk;
  logic        rst;
  logic        s0_vld, s1_vld, pause;
  logic        s0_rdy, s1_rdy;
  logic [7:0]  s0_addr, s1_addr, addr;
  logic [15:0] s0_data, s1_data, data;
  logic        vld;
`ifdef SWITCH_INGRESS_STATS_EN
  logic [15:0] s0_cnt, s1_cnt, full_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] mon_exp;

  typedef struct {
    logic        pause;
    logic        v0;
    logic [7:0]  a0;
    logic [15:0] d0;
    logic        v1;
    logic [7:0]  a1;
    logic [15:0] d1;
    logic        e_vld;
    logic        e_r0;
    logic        e_r1;
    logic [7:0]  e_addr;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl [19];

  switch_ingress_arbiter #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_vld   (s0_vld),
    .s0_rdy   (s0_rdy),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s1_vld   (s1_vld),
    .s1_rdy   (s1_rdy),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .pause    (pause),
`ifdef SWITCH_INGRESS_STATS_EN
    .s0_cnt   (s0_cnt),
    .s1_cnt   (s1_cnt),
    .full_cnt (full_cnt),
`endif
    .addr     (addr),
    .data     (data),
    .vld      (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_vld = 1'b0; s0_addr = '0; s0_data = '0;
    s1_vld = 1'b0; s1_addr = '0; s1_data = '0;
  endtask

  // Scoreboard: at the negedge, inputs and DUT outputs are stable. Output
  // beats are checked first, then beats that will be accepted on the coming
  // edge are queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld) begin
        if (addr[6]) begin
          if (q1.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_src1: unexpected beat %h%h, nothing queued", addr, data);
          end else begin
            mon_exp = q1.pop_front();
            chk("sb_src1", {8'h00, addr, data}, {8'h00, mon_exp});
          end
        end else begin
          if (q0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_src0: unexpected beat %h%h, nothing queued", addr, data);
          end else begin
            mon_exp = q0.pop_front();
            chk("sb_src0", {8'h00, addr, data}, {8'h00, mon_exp});
          end
        end
      end
      if (s0_vld && s0_rdy) q0.push_back({s0_addr, s0_data});
      if (s1_vld && s1_rdy) q1.push_back({s1_addr, s1_data});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // pause, v0, a0, d0, v1, a1, d1, e_vld, e_r0, e_r1, e_addr, e_data
    // Contention: preload both FIFOs while paused, then strict alternation.
    tbl[0]  = '{1'b1, 1'b1, 8'h01, 16'h0001, 1'b1, 8'h41, 16'h1001, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 8'h02, 16'h0002, 1'b1, 8'h42, 16'h1002, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h01, 16'h0001};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h41, 16'h1001};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h02, 16'h0002};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h42, 16'h1002};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h42, 16'h1002};
    // Full: six cycles of s0_vld while paused, only four accepted.
    tbl[7]  = '{1'b1, 1'b1, 8'h11, 16'h0011, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h42, 16'h1002};
    tbl[8]  = '{1'b1, 1'b1, 8'h12, 16'h0012, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h42, 16'h1002};
    tbl[9]  = '{1'b1, 1'b1, 8'h13, 16'h0013, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h42, 16'h1002};
    tbl[10] = '{1'b1, 1'b1, 8'h14, 16'h0014, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h42, 16'h1002};
    tbl[11] = '{1'b1, 1'b1, 8'h15, 16'h0015, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h42, 16'h1002};
    tbl[12] = '{1'b1, 1'b1, 8'h15, 16'h0015, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h42, 16'h1002};
    // Release: push refused on the popping edge, ready back one cycle later.
    tbl[13] = '{1'b0, 1'b1, 8'h15, 16'h0015, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h11, 16'h0011};
    tbl[14] = '{1'b0, 1'b1, 8'h15, 16'h0015, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h12, 16'h0012};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h13, 16'h0013};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h14, 16'h0014};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h15, 16'h0015};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h15, 16'h0015};

    idle_inputs();
    pause = 1'b0;
    rst   = 1'b0;
    #2 rst = 1'b1;
    step();
    step();
    chk("reset_vld", {31'd0, vld}, 32'd0);
    chk("reset_addr", {24'd0, addr}, 32'd0);
    chk("reset_data", {16'd0, data}, 32'd0);
    chk("reset_rdy", {30'd0, s1_rdy, s0_rdy}, 32'd3);
`ifdef SWITCH_INGRESS_STATS_EN
    chk("reset_stats", {16'd0, s0_cnt | s1_cnt | full_cnt}, 32'd0);
`endif
    rst = 1'b0;

    // Table-driven cycles.
    for (int i = 0; i < 19; i++) begin
      pause   = tbl[i].pause;
      s0_vld  = tbl[i].v0; s0_addr = tbl[i].a0; s0_data = tbl[i].d0;
      s1_vld  = tbl[i].v1; s1_addr = tbl[i].a1; s1_data = tbl[i].d1;
      step();
      chk($sformatf("tbl%0d_vld", i), {31'd0, vld}, {31'd0, tbl[i].e_vld});
      chk($sformatf("tbl%0d_rdy", i), {30'd0, s1_rdy, s0_rdy}, {30'd0, tbl[i].e_r1, tbl[i].e_r0});
      chk($sformatf("tbl%0d_beat", i), {8'd0, addr, data}, {8'd0, tbl[i].e_addr, tbl[i].e_data});
      $display("[TB] tbl%0d vld=%0b addr=%h data=%h rdy=%0b%0b", i, vld, addr, data, s1_rdy, s0_rdy);
    end
    idle_inputs();
    pause = 1'b0;

    // Single beat: accepted on edge k, visible after edge k+1, for one cycle.
    s0_vld = 1'b1; s0_addr = 8'h05; s0_data = 16'hABCD;
    step();
    idle_inputs();
    chk("single_k_vld", {31'd0, vld}, 32'd0);
    step();
    chk("single_k1_vld", {31'd0, vld}, 32'd1);
    chk("single_k1_beat", {8'd0, addr, data}, {8'd0, 8'h05, 16'hABCD});
    step();
    chk("single_k2_vld", {31'd0, vld}, 32'd0);
    $display("[TB] single beat addr=%h data=%h", addr, data);

    // Pause mid-stream on source 1.
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s1_vld = 1'b1; s1_addr = 8'h51 + 8'(i); s1_data = 16'h2001 + 16'(i);
      step();
    end
    idle_inputs();
    pause = 1'b0;
    step();
    chk("pause_first", {15'd0, vld, data}, {15'd0, 1'b1, 16'h2001});
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pause_hold%0d", i), {31'd0, vld}, 32'd0);
    end
    pause = 1'b0;
    step();
    chk("pause_second", {15'd0, vld, data}, {15'd0, 1'b1, 16'h2002});
    step();
    chk("pause_third", {15'd0, vld, data}, {15'd0, 1'b1, 16'h2003});
    step();
    chk("pause_done", {31'd0, vld}, 32'd0);
    $display("[TB] pause sequence done");

    // Asynchronous reset with two beats buffered and vld high.
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s0_vld = 1'b1; s0_addr = 8'h21 + 8'(i); s0_data = 16'h3001 + 16'(i);
      step();
    end
    idle_inputs();
    pause = 1'b0;
    step();
    chk("areset_pre_vld", {15'd0, vld, data}, {15'd0, 1'b1, 16'h3001});
    #3;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("areset_vld", {31'd0, vld}, 32'd0);
    chk("areset_rdy", {30'd0, s1_rdy, s0_rdy}, 32'd3);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("areset_stale%0d", i), {31'd0, vld}, 32'd0);
    end
    $display("[TB] async reset sequence done");

`ifdef SWITCH_INGRESS_STATS_EN
    // 5 beats on s0, 3 on s1, two stall cycles on s0.
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0_vld = 1'b1; s0_addr = 8'h31 + 8'(i); s0_data = 16'h4001 + 16'(i);
      s1_vld = (i < 3); s1_addr = 8'h71 + 8'(i); s1_data = 16'h5001 + 16'(i);
      step();
    end
    s1_vld = 1'b0;
    s0_vld = 1'b1; s0_addr = 8'h35; s0_data = 16'h4005;
    step();
    step();
    s0_vld = 1'b0;
    pause  = 1'b0;
    step();
    s0_vld = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 10; i++) step();
    chk("stats_s0_cnt", {16'd0, s0_cnt}, 32'd5);
    chk("stats_s1_cnt", {16'd0, s1_cnt}, 32'd3);
    chk("stats_full_cnt", {16'd0, full_cnt}, 32'd2);
    $display("[TB] stats s0=%0d s1=%0d full=%0d", s0_cnt, s1_cnt, full_cnt);
`endif

    step();
    chk("sb_drained", q0.size() + q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_ingress_arbiter.md
Name: switch_ingress_arbiter

Overview:
- Ingress stage directly upstream of the two-port switch. It drives the switch's single addr/data/vld input.
- Two independent sources push beats through valid/ready handshakes into per-source FIFOs.
- A round-robin arbiter drains one beat per clock into a registered output. The output is a one-cycle vld pulse per beat, matching the switch's input protocol, which has no back-pressure.

Parameters:
- ADDR_WIDTH, 8, width of the destination address field
- DATA_WIDTH, 16, width of the payload field
- DEPTH, 4, entries per source FIFO; power of two, minimum 2

Ports:
- clk  input  1  clock; all state is updated on the rising edge
- rst  input  1  reset, asynchronous, active-high
- s0_vld  input  1  source 0 beat valid
- s0_rdy  output  1  source 0 ready (FIFO 0 not full)
- s0_addr  input  ADDR_WIDTH  source 0 destination address
- s0_data  input  DATA_WIDTH  source 0 payload
- s1_vld  input  1  source 1 beat valid
- s1_rdy  output  1  source 1 ready (FIFO 1 not full)
- s1_addr  input  ADDR_WIDTH  source 1 destination address
- s1_data  input  DATA_WIDTH  source 1 payload
- pause  input  1  when high, the arbiter pops nothing
- addr  output  ADDR_WIDTH  beat address to the switch
- data  output  DATA_WIDTH  beat payload to the switch
- vld  output  1  beat valid to the switch; one cycle per beat

Behaviour:
- Reset (asynchronous assert):
  - vld=0, addr=0, data=0.
  - Both FIFOs empty: pointers 0, count 0, so s0_rdy=s1_rdy=1 after reset.
  - Round-robin pointer last_grant=1, so source 0 wins the first contention.
- Accept:
  - A beat on source i is written on an edge where si_vld && si_rdy.
  - si_rdy = (count_i != DEPTH). It is purely a function of the count; there is no same-cycle pass-through.
  - When full, a push is refused even if a pop occurs in the same cycle; ready re-asserts on the following cycle.
- Arbitration, evaluated each cycle while pause=0:
  - Only FIFO0 non-empty: grant 0.
  - Only FIFO1 non-empty: grant 1.
  - Both non-empty: grant the source that is not last_grant.
  - On a grant, last_grant is updated to the granted source.
  - Neither non-empty, or pause=1: no grant; last_grant holds.
- Output register:
  - On an edge with a grant: addr/data load the head of the granted FIFO, vld=1, and that FIFO pops.
  - On an edge with no grant: vld=0; addr/data hold their last values.
- Latency:
  - A beat accepted on edge k into an empty FIFO with no contention and pause=0 appears with vld=1 after edge k+1.
  - Sustained throughput is 1 beat/clock aggregate.
  - With both FIFOs non-empty, the two sources strictly alternate.
- Simultaneous push and pop on the same FIFO: count unchanged, pointers both advance.
- Pointer wrap: read and write pointers wrap modulo DEPTH; count is tracked separately, with width clog2(DEPTH)+1.
- Ordering: beats from the same source leave in acceptance order. No beat is duplicated or dropped once accepted.
- Reset mid-operation: all buffered beats are discarded, and vld drops immediately (asynchronously).
- pause is sampled each edge. pause rising cancels the next pop; vld=0 from the following edge.

Optional Feature:
- Macro: SWITCH_INGRESS_STATS_EN.
- When defined, three output ports are added:
  - s0_cnt, 16 bits: beats granted from source 0.
  - s1_cnt, 16 bits: beats granted from source 1.
  - full_cnt, 16 bits: cycles where si_vld=1 and si_rdy=0, summed over both sources.
- Each counter increments by 1 per qualifying edge, or by 2 for full_cnt when both sources stall in the same cycle.
- Counters saturate at 16'hFFFF and are cleared by rst.
- When not defined, these ports and their logic are absent, and the remaining behaviour is identical.

Test Plan:
- Single beat:
  - Stimulus: after reset, s0 pushes addr=8'h05, data=16'hABCD on edge k.
  - Required: vld=1 with addr=05, data=ABCD after edge k+1, then vld=0 on the next edge.
- Contention and alternation:
  - Stimulus: both FIFOs preloaded with pause=1 (s0: 8'h01/16'h0001, 8'h02/16'h0002; s1: 8'h41/16'h1001, 8'h42/16'h1002), then pause released.
  - Required output order: 0001, 1001, 0002, 1002 on four consecutive cycles.
- Full / back-pressure:
  - Stimulus: pause=1, s0 holds vld for 6 cycles with DEPTH=4.
  - Required: exactly 4 beats accepted and s0_rdy=0 from the 4th acceptance onward. After pause=0, the 4 beats are output in order, and s0_rdy=1 one cycle after the first pop.
- Pause mid-stream:
  - Stimulus: 3 beats queued on s1; pause=1 asserted after the first output beat.
  - Required: exactly 1 vld pulse, then vld=0 while paused. After release, the remaining 2 beats are output with no loss.
- Asynchronous reset mid-operation:
  - Stimulus: rst asserted between edges while 2 beats are buffered and vld=1.
  - Required: vld=0 immediately and s0_rdy=s1_rdy=1. No stale beats are output after reset release.
- SWITCH_INGRESS_STATS_EN:
  - Stimulus: 5 beats through s0, 3 through s1, and 2 stall cycles on s0.
  - Required: s0_cnt=5, s1_cnt=3, full_cnt=2.
